sync_sram: RTL and testbench

SYNC_SRAM -- requirements
Module: sync_sram

---
 rtl/sram_pkg.sv | 15 +
 rtl/rd_pipe.sv | 46 ++++
 rtl/sync_sram.sv | 96 +++++++++
 tb/tb_sync_sram.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and parameter defaults for the synchronous SRAM block.
// Holds the INIT/RUN state encoding used by the controller FSM.
package sram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DW_DEFAULT             = 8;
   localparam int AW_DEFAULT             = 8;
   localparam int RD_LAT_DEFAULT         = 1;
   localparam int CLEAR_ON_RESET_DEFAULT = 1;

endpackage

// File: rtl/rd_pipe.sv
// Read-response delay line: LAT stages of valid plus data, latency LAT cycles.
// No backpressure; out_dat holds its last value while out_vld is low.
module rd_pipe #(
   parameter int DW  = 8,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_vld,
   input  logic [DW-1:0] in_dat,
   output logic          out_vld,
   output logic [DW-1:0] out_dat
);

   logic [LAT-1:0] vld_q;
   logic [LAT-1:0] vld_nxt;
   logic [DW-1:0]  dat_q   [LAT];
   logic [DW-1:0]  dat_nxt [LAT];

   always_comb begin
      vld_nxt    = '0;
      vld_nxt[0] = in_vld;
      dat_nxt[0] = in_dat;
      for (int i = 1; i < LAT; i++) begin
         vld_nxt[i] = vld_q[i-1];
         dat_nxt[i] = dat_q[i-1];
      end
   end

   // Data stages only load behind a valid, so the last stage holds between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
      end else begin
         vld_q <= vld_nxt;
         for (int i = 0; i < LAT; i++) begin
            if (vld_nxt[i]) dat_q[i] <= dat_nxt[i];
         end
      end
   end

   assign out_vld = vld_q[LAT-1];
   assign out_dat = dat_q[LAT-1];

endmodule

// File: rtl/sync_sram.sv
// Single-port synchronous SRAM with optional zero-fill after reset; reads respond RD_LAT cycles after accept.
// req_ready is low only during INIT; responses cannot be stalled.
module sync_sram
   import sram_pkg::*;
#(
   parameter int DW             = DW_DEFAULT,
   parameter int AW             = AW_DEFAULT,
   parameter int RD_LAT         = RD_LAT_DEFAULT,
   parameter int CLEAR_ON_RESET = CLEAR_ON_RESET_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wr,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          init_done
);

   localparam int            DEPTH     = 2**AW;
   localparam logic [AW-1:0] LAST_ADDR = '1;

   state_t          state;
   logic [AW-1:0]   fill_cnt;
   logic [DW-1:0]   mem [DEPTH];
   logic            acc;
   logic            fill_we;
   logic            rd_vld_q;
   logic [AW-1:0]   rd_addr_q;
   logic [DW-1:0]   rd_dat;

   assign acc     = req_valid && req_ready && !rst;
   assign fill_we = (state == INIT) && (CLEAR_ON_RESET != 0) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         fill_cnt  <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               // Terminal count ends the fill; the counter never wraps into a second pass.
               if ((CLEAR_ON_RESET == 0) || (fill_cnt == LAST_ADDR)) begin
                  state     <= RUN;
                  req_ready <= 1'b1;
                  init_done <= 1'b1;
               end else begin
                  fill_cnt <= fill_cnt + 1'b1;
               end
            end
            RUN:     state <= RUN;
            default: state <= INIT;
         endcase
      end
   end

   // The array itself is never reset; only the INIT fill clears it.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[fill_cnt] <= '0;
      end else if (acc && req_wr) begin
         mem[req_addr] <= req_wdata;
      end
   end

   // Address register: the array is read one edge after accept, after any write at the accept edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q  <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         rd_vld_q <= acc && !req_wr;
         if (acc) rd_addr_q <= req_addr;
      end
   end

   assign rd_dat = mem[rd_addr_q];

   rd_pipe #(
      .DW  (DW),
      .LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (rd_vld_q),
      .in_dat  (rd_dat),
      .out_vld (rsp_valid),
      .out_dat (rsp_rdata)
   );

endmodule

// File: tb/tb_sync_sram.sv
// Scoreboard bench for sync_sram: three configurations (RD_LAT=2 fill, AW=4 fill, no fill).
// Stimulus pushes expected read data and arrival cycle; a negedge monitor pops and compares.
module tb_sync_sram;

   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] rst;
   logic [N-1:0] req_valid;
   logic [N-1:0] req_ready;
   logic [N-1:0] req_wr;
   logic [N-1:0] rsp_valid;
   logic [N-1:0] init_done;
   logic [7:0]   req_addr  [N];
   logic [7:0]   req_wdata [N];
   logic [7:0]   rsp_rdata [N];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         inst;
      int         cyc;
      logic [7:0] dat;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   rsp_cnt [N] = '{0, 0, 0};

   sync_sram #(.DW(8), .AW(8), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .init_done(init_done[0]));

   sync_sram #(.DW(8), .AW(4), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_wr(req_wr[1]), .req_addr(req_addr[1][3:0]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .init_done(init_done[1]));

   sync_sram #(.DW(8), .AW(8), .RD_LAT(1), .CLEAR_ON_RESET(0)) dut2 (
      .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_wr(req_wr[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .init_done(init_done[2]));

   function automatic int lat_of(int i);
      return (i == 0) ? 2 : 1;
   endfunction

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest expected entry in instance, cycle and data.
   always @(negedge clk) begin : monitor
      exp_t e;
      for (int i = 0; i < N; i++) begin
         if (rsp_valid[i]) begin
            rsp_cnt[i]++;
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_rsp: inst %0d data 0x%0h at cycle %0d with nothing expected",
                        i, rsp_rdata[i], cyc);
            end else begin
               e = q.pop_front();
               if (e.inst != i || e.cyc != cyc || e.dat != rsp_rdata[i]) begin
                  bad++;
                  $display("FAIL rsp: got inst %0d cyc %0d data 0x%0h want inst %0d cyc %0d data 0x%0h",
                           i, cyc, rsp_rdata[i], e.inst, e.cyc, e.dat);
               end
            end
         end
      end
   end

   // For reads, d is the expected response data.
   task automatic issue(int i, logic wr, logic [7:0] a, logic [7:0] d);
      @(negedge clk);
      req_valid[i] = 1'b1;
      req_wr[i]    = wr;
      req_addr[i]  = a;
      req_wdata[i] = d;
      check("req_ready_before_issue", int'(req_ready[i]), 1);
      @(posedge clk);
      #1;
      if (!wr) q.push_back('{inst: i, cyc: cyc + lat_of(i), dat: d});
   endtask

   task automatic idle(int i);
      @(negedge clk);
      req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", q.size(), 0);
   endtask

   // Called at the negedge where rst[i] was just released.
   task automatic wait_init(int i, int exp_cycles, string name);
      int n;
      n = 0;
      while (!init_done[i] && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(name, n, exp_cycles);
      check("req_ready_after_init", int'(req_ready[i]), 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int done_at [N];
      int base;
      done_at   = '{0, 0, 0};
      rst       = '1;
      req_valid = '0;
      req_wr    = '0;
      for (int i = 0; i < N; i++) begin
         req_addr[i]  = '0;
         req_wdata[i] = '0;
      end

      // Reset state.
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check("reset_req_ready", int'(req_ready[i]), 0);
         check("reset_init_done", int'(init_done[i]), 0);
         check("reset_rsp_valid", int'(rsp_valid[i]), 0);
         check("reset_rsp_rdata", int'(rsp_rdata[i]), 0);
      end

      // Release all; inst0 holds a write to 0x05 during INIT, which must be ignored.
      req_valid[0] = 1'b1;
      req_wr[0]    = 1'b1;
      req_addr[0]  = 8'h05;
      req_wdata[0] = 8'h7E;
      rst          = '0;
      for (int n = 1; n <= 400 && !(&init_done); n++) begin
         @(negedge clk);
         if (n == 15) check("aw4_ready_low_cycle15", int'(req_ready[1]), 0);
         for (int i = 0; i < N; i++) begin
            if (init_done[i] && done_at[i] == 0) done_at[i] = n;
         end
         if (init_done[0]) req_valid[0] = 1'b0;
      end
      check("init_cycles_aw8", done_at[0], 256);
      check("init_cycles_aw4", done_at[1], 16);
      check("init_cycles_noclear", done_at[2], 1);

      // AW=4: top address reads zero after fill.
      issue(1, 1'b0, 8'h0F, 8'h00);
      issue(1, 1'b0, 8'h00, 8'h00);
      idle(1);
      drain();

      // Write held during INIT left 0x05 untouched; then write/read-next-cycle at RD_LAT=2.
      issue(0, 1'b0, 8'h05, 8'h00);
      issue(0, 1'b1, 8'h03, 8'hA5);
      issue(0, 1'b0, 8'h03, 8'hA5);
      idle(0);
      drain();

      // Boundary addresses, then four back-to-back reads.
      issue(0, 1'b1, 8'h00, 8'h11);
      issue(0, 1'b1, 8'h01, 8'h22);
      issue(0, 1'b1, 8'hFE, 8'h33);
      issue(0, 1'b1, 8'hFF, 8'h44);
      issue(0, 1'b0, 8'h00, 8'h11);
      issue(0, 1'b0, 8'h01, 8'h22);
      issue(0, 1'b0, 8'hFE, 8'h33);
      issue(0, 1'b0, 8'hFF, 8'h44);
      idle(0);
      drain();

      // Read data holds while no response is presented.
      repeat (3) @(negedge clk);
      check("hold_rsp_valid", int'(rsp_valid[0]), 0);
      check("hold_rsp_rdata", int'(rsp_rdata[0]), 8'h44);

      // Reset with two reads in flight: both are discarded and the fill restarts.
      issue(0, 1'b0, 8'h00, 8'h11);
      issue(0, 1'b0, 8'h01, 8'h22);
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst[0]       = 1'b1;
      q.delete();
      base = rsp_cnt[0];
      repeat (2) @(negedge clk);
      check("midreset_init_done", int'(init_done[0]), 0);
      check("midreset_req_ready", int'(req_ready[0]), 0);
      rst[0] = 1'b0;
      wait_init(0, 256, "refill_cycles_aw8");
      check("no_rsp_after_reset", rsp_cnt[0] - base, 0);
      issue(0, 1'b0, 8'hFF, 8'h00);
      issue(0, 1'b0, 8'h00, 8'h00);
      idle(0);
      drain();

      // No-fill configuration keeps contents across reset.
      issue(2, 1'b1, 8'h10, 8'h5A);
      @(negedge clk);
      req_valid[2] = 1'b0;
      rst[2]       = 1'b1;
      @(negedge clk);
      rst[2] = 1'b0;
      wait_init(2, 1, "noclear_reinit_cycles");
      issue(2, 1'b0, 8'h10, 8'h5A);
      idle(2);
      drain();

      check("rsp_count_inst0", rsp_cnt[0], 8);
      check("rsp_count_inst1", rsp_cnt[1], 2);
      check("rsp_count_inst2", rsp_cnt[2], 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
